// File: rtl/bus_stream_pkg.sv
// bus_stream_pkg: shared sizing helpers and tagged-word layout for bus_stream_mux.
// A tagged word is {id, payload}. The payload occupies bits [DataWidth-1:0] and
// the channel id sits directly above it, starting at bit DataWidth.
package bus_stream_pkg;

  localparam int unsigned DropCntWidth = 16;
  localparam int unsigned PayloadLsb   = 0;

  // Channel id width: ceil(log2(num_channels)), never below one bit.
  function automatic int unsigned id_width(input int unsigned num_channels);
    return (num_channels <= 2) ? 32'd1 : 32'($clog2(num_channels));
  endfunction

  // Bit position of the id field inside a tagged word.
  function automatic int unsigned id_lsb(input int unsigned data_width);
    return data_width;
  endfunction

  // Total width of a tagged word.
  function automatic int unsigned tag_width(input int unsigned data_width,
                                            input int unsigned num_channels);
    return data_width + id_width(num_channels);
  endfunction

endpackage

// File: rtl/bus_stream_mux_if.sv
// bus_stream_mux_if: downstream link of the mux.
//   tx_data_o/tx_valid_o : tagged words leaving the mux
//   tx_busy_i            : downstream back-pressure
//   rx_data_i/rx_valid_i : tagged return words entering the mux
// master = mux side, slave = downstream side.
interface bus_stream_mux_if #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned NumChannels = 4
);
  localparam int unsigned TagWidth = bus_stream_pkg::tag_width(DataWidth, NumChannels);

  logic [TagWidth-1:0] tx_data_o;
  logic                tx_valid_o;
  logic                tx_busy_i;
  logic [TagWidth-1:0] rx_data_i;
  logic                rx_valid_i;

  modport master (
    output tx_data_o, tx_valid_o,
    input  tx_busy_i, rx_data_i, rx_valid_i
  );

  modport slave (
    input  tx_data_o, tx_valid_o,
    output tx_busy_i, rx_data_i, rx_valid_i
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**AddrWidth words.
// Ports: clk_i, reset_n_i (async active-low, clears pointers/count only);
//   wr_en_i/wr_data_i write side, ignored when full at the start of the cycle;
//   rd_en_i pops, rd_data_c is the combinational head word;
//   count_o registered occupancy, full_c/empty_c combinational flags.
module sync_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_en_i,
  output logic [DataWidth-1:0] rd_data_c,
  output logic [AddrWidth:0]   count_o,
  output logic                 full_c,
  output logic                 empty_c
);

  localparam int unsigned Depth    = 1 << AddrWidth;
  localparam int unsigned CntWidth = AddrWidth + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrWidth-1:0] wr_ptr_q;
  logic [AddrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0]  count_q;
  logic                 wr_fire;
  logic                 rd_fire;

  assign full_c    = (count_q == CntWidth'(Depth));
  assign empty_c   = (count_q == '0);
  assign wr_fire   = wr_en_i && !full_c;
  assign rd_fire   = rd_en_i && !empty_c;
  assign rd_data_c = mem[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      count_q <= count_q + CntWidth'(wr_fire) - CntWidth'(rd_fire);
    end
  end

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/bus_stream_mux.sv
// bus_stream_mux: merges NumChannels client write streams into one tagged
// downstream stream via per-channel FIFOs and a round-robin arbiter, and
// fans tagged return words back out to the clients.
// Ports: clk_i, reset_n_i (async active-low);
//   ch_data_i/ch_valid_i client writes, ch_busy_o per-channel almost-full;
//   ch_data_o/ch_valid_o return payload and one-hot return strobe;
//   bus (master) carries tx_data_o/tx_valid_o/tx_busy_i and rx_data_i/rx_valid_i;
//   drop_cnt_o per-channel saturating drop counters, only when
//   BUS_STREAM_MUX_DROP_CNT_EN is defined.
module bus_stream_mux
  import bus_stream_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned FifoAddrWidth = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [NumChannels*DataWidth-1:0] ch_data_i,
  input  logic [NumChannels-1:0]           ch_valid_i,
  output logic [NumChannels-1:0]           ch_busy_o,
  output logic [DataWidth-1:0]             ch_data_o,
  output logic [NumChannels-1:0]           ch_valid_o,
`ifdef BUS_STREAM_MUX_DROP_CNT_EN
  output logic [NumChannels*DropCntWidth-1:0] drop_cnt_o,
`endif
  bus_stream_mux_if.master                 bus
);

  localparam int unsigned IdWidth  = id_width(NumChannels);
  localparam int unsigned Depth    = 1 << FifoAddrWidth;
  localparam int unsigned CntWidth = FifoAddrWidth + 1;

  logic [DataWidth-1:0]   fifo_rd_data [NumChannels];
  logic [CntWidth-1:0]    fifo_count   [NumChannels];
  logic [NumChannels-1:0] fifo_full;
  logic [NumChannels-1:0] fifo_empty;
  logic [NumChannels-1:0] fifo_rd_en;
  logic [NumChannels-1:0] wr_accept;

  logic [IdWidth-1:0]     last_q;
  logic                   grant_found;
  logic                   grant;
  logic [IdWidth-1:0]     grant_id;
  logic [DataWidth-1:0]   grant_data;

  logic [IdWidth-1:0]     rx_id;
  logic [DataWidth-1:0]   rx_payload;
  logic                   rx_hit;

  // Per-channel FIFOs; a write is accepted only when the FIFO was not full
  // at the start of the cycle, regardless of a same-cycle pop.
  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    assign wr_accept[g] = ch_valid_i[g] && !fifo_full[g];
    assign ch_busy_o[g] = (fifo_count[g] >= CntWidth'(Depth - 1));

    sync_fifo #(
      .DataWidth (DataWidth),
      .AddrWidth (FifoAddrWidth)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .wr_en_i   (wr_accept[g]),
      .wr_data_i (ch_data_i[g*DataWidth +: DataWidth]),
      .rd_en_i   (fifo_rd_en[g]),
      .rd_data_c (fifo_rd_data[g]),
      .count_o   (fifo_count[g]),
      .full_c    (fifo_full[g]),
      .empty_c   (fifo_empty[g])
    );
  end

  // Round-robin search: first non-empty channel strictly after last_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    for (int unsigned k = 1; k <= NumChannels; k++) begin
      if (!grant_found && !fifo_empty[(32'(last_q) + k) % NumChannels]) begin
        grant_found = 1'b1;
        grant_id    = IdWidth'((32'(last_q) + k) % NumChannels);
        grant_data  = fifo_rd_data[(32'(last_q) + k) % NumChannels];
      end
    end
  end

  assign grant      = grant_found && !bus.tx_busy_i;
  assign fifo_rd_en = grant ? (NumChannels'(1) << grant_id) : '0;

  // Tx output register and last-granted pointer; tx_data_o holds between words.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bus.tx_valid_o <= 1'b0;
      bus.tx_data_o  <= '0;
      last_q         <= IdWidth'(NumChannels - 1);
    end else begin
      bus.tx_valid_o <= grant;
      if (grant) begin
        bus.tx_data_o <= {grant_id, grant_data};
        last_q        <= grant_id;
      end
    end
  end

  assign rx_id      = bus.rx_data_i[id_lsb(DataWidth) +: IdWidth];
  assign rx_payload = bus.rx_data_i[PayloadLsb +: DataWidth];
  assign rx_hit     = bus.rx_valid_i && (32'(rx_id) < NumChannels);

  // Return path: out-of-range ids are discarded without a strobe.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ch_valid_o <= '0;
      ch_data_o  <= '0;
    end else begin
      ch_valid_o <= rx_hit ? (NumChannels'(1) << rx_id) : '0;
      if (rx_hit) ch_data_o <= rx_payload;
    end
  end

`ifdef BUS_STREAM_MUX_DROP_CNT_EN
  logic [DropCntWidth-1:0] drop_cnt_q [NumChannels];

  // Saturating count of writes refused because the FIFO was full.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < NumChannels; i++) drop_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (ch_valid_i[i] && fifo_full[i] && (drop_cnt_q[i] != '1)) begin
          drop_cnt_q[i] <= drop_cnt_q[i] + DropCntWidth'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_drop
    assign drop_cnt_o[g*DropCntWidth +: DropCntWidth] = drop_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_bus_stream_mux.sv
// tb_bus_stream_mux: queue-based reference model of the mux, compared every
// cycle, plus directed sequences with literal expectations and a random phase.
module tb_bus_stream_mux;
  import bus_stream_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned N3    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N*DW-1:0]  ch_data  = '0;
  logic [N-1:0]     ch_valid = '0;
  logic [N-1:0]     ch_busy;
  logic [N-1:0]     chv_out;
  logic [DW-1:0]    chd_out;

  logic [N3*DW-1:0] ch_data3  = '0;
  logic [N3-1:0]    ch_valid3 = '0;
  logic [N3-1:0]    busy3;
  logic [N3-1:0]    chv3_out;
  logic [DW-1:0]    chd3_out;

`ifdef BUS_STREAM_MUX_DROP_CNT_EN
  logic [N*16-1:0]  drop_cnt;
  logic [N3*16-1:0] drop_cnt3;
`endif

  bus_stream_mux_if #(.DataWidth(DW), .NumChannels(N))  bus  ();
  bus_stream_mux_if #(.DataWidth(DW), .NumChannels(N3)) bus3 ();

  assign bus3.tx_busy_i  = 1'b1;
  assign bus3.rx_data_i  = bus.rx_data_i;
  assign bus3.rx_valid_i = bus.rx_valid_i;

  bus_stream_mux #(.DataWidth(DW), .NumChannels(N), .FifoAddrWidth(AW)) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .ch_data_i  (ch_data),
    .ch_valid_i (ch_valid),
    .ch_busy_o  (ch_busy),
    .ch_data_o  (chd_out),
    .ch_valid_o (chv_out),
`ifdef BUS_STREAM_MUX_DROP_CNT_EN
    .drop_cnt_o (drop_cnt),
`endif
    .bus        (bus)
  );

  bus_stream_mux #(.DataWidth(DW), .NumChannels(N3), .FifoAddrWidth(AW)) dut3 (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .ch_data_i  (ch_data3),
    .ch_valid_i (ch_valid3),
    .ch_busy_o  (busy3),
    .ch_data_o  (chd3_out),
    .ch_valid_o (chv3_out),
`ifdef BUS_STREAM_MUX_DROP_CNT_EN
    .drop_cnt_o (drop_cnt3),
`endif
    .bus        (bus3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]    mq [N][$];
  int               last     = N - 1;
  logic             exp_txv  = 1'b0;
  logic [IW+DW-1:0] exp_txd  = '0;
  logic [N-1:0]     exp_chv  = '0;
  logic [DW-1:0]    exp_chd  = '0;
  logic [N3-1:0]    exp_chv3 = '0;
  logic [DW-1:0]    exp_chd3 = '0;
  int               drops [N];
  int               sz0 [N];
  int               rid;
  int               cand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        drops[i] = 0;
      end
      last     = N - 1;
      exp_txv  = 1'b0;
      exp_txd  = '0;
      exp_chv  = '0;
      exp_chd  = '0;
      exp_chv3 = '0;
      exp_chd3 = '0;
    end else begin
      for (int i = 0; i < N; i++) sz0[i] = mq[i].size();
      exp_txv = 1'b0;
      if (!bus.tx_busy_i) begin
        for (int k = 1; k <= N; k++) begin
          cand = (last + k) % N;
          if (!exp_txv && sz0[cand] > 0) begin
            exp_txv = 1'b1;
            exp_txd = {IW'(cand), mq[cand].pop_front()};
            last    = cand;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i]) begin
          if (sz0[i] >= DEPTH) begin
            if (drops[i] < 65535) drops[i]++;
          end else begin
            mq[i].push_back(ch_data[i*DW +: DW]);
          end
        end
      end
      rid = int'(bus.rx_data_i[DW +: IW]);
      exp_chv  = '0;
      exp_chv3 = '0;
      if (bus.rx_valid_i) begin
        exp_chv[rid] = 1'b1;
        exp_chd      = bus.rx_data_i[DW-1:0];
        if (rid < N3) begin
          exp_chv3[rid] = 1'b1;
          exp_chd3      = bus.rx_data_i[DW-1:0];
        end
      end
    end
  end

  // ---------------- every-cycle comparison ----------------
  logic [IW+DW-1:0] tx_log [$];
  logic [N-1:0]     exp_busy;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) exp_busy[i] = (mq[i].size() >= DEPTH - 1);
    chk("tx_valid", 64'(bus.tx_valid_o), 64'(exp_txv));
    chk("tx_data",  64'(bus.tx_data_o),  64'(exp_txd));
    chk("ch_valid", 64'(chv_out),        64'(exp_chv));
    chk("ch_data",  64'(chd_out),        64'(exp_chd));
    chk("ch_busy",  64'(ch_busy),        64'(exp_busy));
    chk("n3_ch_valid", 64'(chv3_out),    64'(exp_chv3));
    chk("n3_ch_data",  64'(chd3_out),    64'(exp_chd3));
    chk("n3_tx_valid", 64'(bus3.tx_valid_o), 64'(0));
`ifdef BUS_STREAM_MUX_DROP_CNT_EN
    for (int i = 0; i < N; i++)
      chk("drop_cnt", 64'(drop_cnt[i*16 +: 16]), 64'(drops[i]));
`endif
    if (bus.tx_valid_o) tx_log.push_back(bus.tx_data_o);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_valid       = '0;
    ch_data        = '0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = '0;
  endtask

  logic [IW+DW-1:0] entry;

  initial begin
    idle_inputs();
    bus.tx_busy_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    chk("rst_tx_data",  64'(bus.tx_data_o),  64'(0));
    chk("rst_ch_busy",  64'(ch_busy),        64'(0));
    tick();
    rst_n = 1'b1;

    // Same-cycle writes to ch0 and ch2 leave back to back in grant order.
    tick();
    ch_valid = 4'b0101;
    ch_data  = '0;
    ch_data[0*DW +: DW] = 8'hA1;
    ch_data[2*DW +: DW] = 8'hB2;
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    chk("dir_tx0_valid", 64'(bus.tx_valid_o), 64'(1));
    chk("dir_tx0_data",  64'(bus.tx_data_o),  64'({2'd0, 8'hA1}));
    @(negedge clk);
    chk("dir_tx1_valid", 64'(bus.tx_valid_o), 64'(1));
    chk("dir_tx1_data",  64'(bus.tx_data_o),  64'({2'd2, 8'hB2}));
    repeat (3) tick();

    // Five writes into ch1 while downstream is busy; the fifth is dropped.
    bus.tx_busy_i = 1'b1;
    ch_valid = 4'b0010;
    ch_data  = '0;
    for (int w = 0; w < 5; w++) begin
      ch_data[1*DW +: DW] = 8'(8'h10 + w);
      tick();
      @(negedge clk);
      if (w == 1) chk("dir_busy_after2", 64'(ch_busy[1]), 64'(0));
      if (w == 2) chk("dir_busy_after3", 64'(ch_busy[1]), 64'(1));
      #4;
    end
    idle_inputs();
`ifdef BUS_STREAM_MUX_DROP_CNT_EN
    chk("dir_drop_ch1", 64'(drop_cnt[16 +: 16]), 64'(1));
`endif
    bus.tx_busy_i = 1'b0;
    tick();
    @(negedge clk);
    chk("dir_drain_first", 64'(bus.tx_data_o), 64'({2'd1, 8'h10}));
    repeat (6) tick();

    // Return path, including an id that only the 3-channel instance rejects.
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = {2'd3, 8'h5C};
    tick();
    bus.rx_data_i  = {2'd2, 8'h77};
    @(negedge clk);
    chk("dir_rx_strobe",   64'(chv_out),  64'(4'b1000));
    chk("dir_rx_data",     64'(chd_out),  64'(8'h5C));
    chk("dir_rx_n3_none",  64'(chv3_out), 64'(3'b000));
    tick();
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    chk("dir_rx_n3_strobe", 64'(chv3_out), 64'(3'b100));
    chk("dir_rx_n3_data",   64'(chd3_out), 64'(8'h77));
    tick();
    @(negedge clk);
    chk("dir_rx_pulse_end", 64'(chv_out), 64'(0));
    tick();

    // Reset with loaded FIFOs: everything clears at once and nothing stale leaves.
    bus.tx_busy_i = 1'b1;
    ch_valid = 4'b1111;
    for (int w = 0; w < 3; w++) begin
      ch_data = {4{8'(8'h30 + w)}};
      tick();
    end
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    chk("rst_mid_tx_data",  64'(bus.tx_data_o),  64'(0));
    chk("rst_mid_ch_data",  64'(chd_out),        64'(0));
    chk("rst_mid_ch_busy",  64'(ch_busy),        64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    bus.tx_busy_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(bus.tx_valid_o), 64'(0));
    end
    tick();

    // All channels loaded: rotation 0,1,2,3,0,... with a busy pause in between.
    tx_log.delete();
    bus.tx_busy_i = 1'b1;
    ch_valid = 4'b1111;
    ch_data  = 32'h44332211;
    tick();
    ch_data  = 32'h88776655;
    tick();
    idle_inputs();
    bus.tx_busy_i = 1'b0;
    repeat (2) tick();
    bus.tx_busy_i = 1'b1;
    repeat (2) tick();
    bus.tx_busy_i = 1'b0;
    repeat (10) tick();
    chk("rr_count", 64'(tx_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < tx_log.size(); i++) begin
      entry = tx_log[i];
      chk("rr_order", 64'(entry[DW +: IW]), 64'(i % 4));
    end
    chk("rr_word4", 64'(tx_log.size() > 4 ? tx_log[4] : '0), 64'({2'd0, 8'h55}));

    // Random traffic with one reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      ch_valid       = N'($urandom_range(0, 15));
      ch_data        = $urandom();
      bus.tx_busy_i  = ($urandom_range(0, 9) < 4);
      bus.rx_valid_i = $urandom_range(0, 1) == 1;
      bus.rx_data_i  = (IW+DW)'($urandom());
      if (c == 1000) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    idle_inputs();
    bus.tx_busy_i = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_stream_mux.md
BUS_STREAM_MUX -- requirements
Module: bus_stream_mux

Interface
REQ-001 SHALL have parameter DataWidth, default 8, payload bits per word.
REQ-002 SHALL have parameter NumChannels, default 4, range 2..16, number of client channels.
REQ-003 SHALL have parameter FifoAddrWidth, default 2, so each channel FIFO holds 2**FifoAddrWidth words.
REQ-004 SHALL have ports: clk_i in 1, the only clock; reset_n_i in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: ch_data_i in NumChannels*DataWidth, client write data; ch_valid_i in NumChannels, per-channel write strobes; ch_busy_o out NumChannels, per-channel almost-full flags.
REQ-006 SHALL have ports: tx_data_o out IdWidth+DataWidth, tagged word {id,payload}; tx_valid_o out 1, one-cycle word strobe; tx_busy_i in 1, downstream busy.
REQ-007 SHALL have ports: rx_data_i in IdWidth+DataWidth, tagged return word; rx_valid_i in 1, return strobe.
REQ-008 SHALL have ports: ch_data_o out DataWidth, return payload shared by all channels; ch_valid_o out NumChannels, one-hot return strobe.
REQ-009 SHALL have port drop_cnt_o out NumChannels*16, per-channel drop counters, present only with BUS_STREAM_MUX_DROP_CNT_EN.

Function
REQ-010 SHALL compute IdWidth as ceil(log2(NumChannels)), minimum 1.
REQ-011 SHALL write ch_data_i slice i into FIFO i on any cycle where ch_valid_i[i]=1 and FIFO i is not full at the start of that cycle; otherwise the word is dropped.
REQ-012 SHALL treat a write arriving at a full FIFO as dropped even if the same FIFO is read that cycle.
REQ-013 SHALL assert ch_busy_o[i] combinationally when FIFO i count >= depth-1.
REQ-014 SHALL run a round-robin arbiter: each cycle with tx_busy_i=0, grant the lowest non-empty channel index strictly above the last granted index, wrapping from NumChannels-1 to 0.
REQ-015 SHALL pop the granted FIFO and register {granted id, word} onto tx_data_o with tx_valid_o=1 on the next edge; latency from accepted write to tx_valid_o SHALL be at least 2 cycles.
REQ-016 SHALL issue at most one tx word per cycle, and no word on any cycle where tx_busy_i=1 is sampled; tx_data_o SHALL hold its last value while tx_valid_o=0.
REQ-017 SHALL update the last-granted pointer only on an actual grant; reset value NumChannels-1, so channel 0 wins first.
REQ-018 SHALL, on rx_valid_i=1 with id < NumChannels, register payload to ch_data_o and pulse ch_valid_o[id] for exactly one cycle, 1-cycle latency.
REQ-019 SHALL discard rx words with id >= NumChannels and assert no ch_valid_o bit.
REQ-020 SHALL process tx and rx paths independently in the same cycle.

Reset
REQ-021 SHALL asynchronously clear all FIFO pointers, tx_valid_o, ch_valid_o, tx_data_o, ch_data_o and drop counters to 0 while reset_n_i=0.
REQ-022 SHALL discard FIFO contents on reset mid-operation; first grant after release SHALL be channel 0 if non-empty.
REQ-023 SHALL deassert ch_busy_o during and after reset until FIFOs refill.

Configuration
REQ-024 SHALL, with BUS_STREAM_MUX_DROP_CNT_EN defined, increment drop_cnt_o slice i by 1 on every dropped write to channel i, saturating at 16'hFFFF.
REQ-025 SHALL, without BUS_STREAM_MUX_DROP_CNT_EN, omit drop_cnt_o and all counter logic; behaviour otherwise identical.

Structure
REQ-026 SHALL place the IdWidth helper function and the tagged-word field layout in shared package bus_stream_pkg.
REQ-027 SHALL instantiate NumChannels copies of one sub-module, sync_fifo (single-clock, count output, full/empty flags).

Verification
REQ-028 SHALL cover: writes 8'hA1 ch0, 8'hB2 ch2 same cycle, tx_busy_i=0 -> tx {0,A1} then {2,B2} on consecutive cycles.
REQ-029 SHALL cover: 5 writes to ch1 (depth 4) with tx_busy_i=1 -> ch_busy_o[1]=1 after 3rd, 5th dropped, drop_cnt ch1=1, 4 words drain in order once busy clears.
REQ-030 SHALL cover: all 4 channels held non-empty -> grant order 0,1,2,3,0; tx_busy_i toggled mid-sequence pauses without skipping a channel.
REQ-031 SHALL cover: rx_data_i={3,8'h5C} valid -> ch_valid_o=4'b1000, ch_data_o=8'h5C next cycle; NumChannels=3 with id 3 -> no strobe.
REQ-032 SHALL cover: reset_n_i pulsed low with FIFOs half full -> outputs 0 immediately, no stale word emitted after release.
